// File: rtl/bcd_to_decimal_decoder.sv
// Sequential BCD-to-decimal decoder: unpacks a word of BCD digits and presents them MSD-first as one-hot codes.
// Optional error counter (ports err_clr/err_count) is built when BCD_DEC_ERR_CNT_EN is defined.
module bcd_to_decimal_decoder #(
    parameter int DIGITS    = 4,
    parameter int ERR_CNT_W = 8,
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef BCD_DEC_ERR_CNT_EN
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [9:0]            out_onehot,
    output logic                  out_err,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last
);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("DIGITS must be in 1..8");
    end
    if (ERR_CNT_W < 1) begin : g_bad_cnt_w
        $error("ERR_CNT_W must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(DIGITS - 1);

    state_e                state_q;
    logic [4*DIGITS-1:0]   word_q;
    logic [IDX_W-1:0]      idx_q;
    logic [9:0]            onehot_q;
    logic                  err_q;

    logic                  accept;
    logic                  handoff;
    logic                  step;
    logic [IDX_W-1:0]      idx_d;
    logic [10:0]           load_dec;
    logic [10:0]           step_dec;

    // Selecting with constant indices keeps the mux free of out-of-range slices for non power-of-two DIGITS.
    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] word,
                                            input logic [IDX_W-1:0]    idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                d = word[4*i +: 4];
            end
        end
        return d;
    endfunction

    // Returns {err, onehot}; codes 10-15 produce an all-zero one-hot with err set.
    function automatic logic [10:0] decode(input logic [3:0] d);
        logic [10:0] r;
        r = '0;
        if (d > 4'd9) begin
            r[10] = 1'b1;
        end else begin
            r[d] = 1'b1;
        end
        return r;
    endfunction

    assign out_valid  = (state_q == BUSY);
    assign out_last   = (idx_q == '0);
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign out_err    = err_q;

    assign in_ready = !out_valid || (out_ready && out_last);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;
    assign step     = handoff && !out_last;

    // NOTE: every signal written here gets a value on every path first, so no latch can be inferred.
    always_comb begin
        idx_d    = idx_q - 1'b1;
        load_dec = decode(digit_at(in_bcd, TOP_IDX));
        step_dec = decode(digit_at(word_q, idx_d));
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the word buffer is deliberately reset; a word interrupted by reset must never resume.
            state_q  <= IDLE;
            word_q   <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= BUSY;
                        word_q   <= in_bcd;
                        idx_q    <= TOP_IDX;
                        onehot_q <= load_dec[9:0];
                        err_q    <= load_dec[10];
                    end
                end
                BUSY: begin
                    if (accept) begin
                        // Last digit handed off while a new word waits: reload with no bubble.
                        word_q   <= in_bcd;
                        idx_q    <= TOP_IDX;
                        onehot_q <= load_dec[9:0];
                        err_q    <= load_dec[10];
                    end else if (step) begin
                        idx_q    <= idx_d;
                        onehot_q <= step_dec[9:0];
                        err_q    <= step_dec[10];
                    end else if (handoff) begin
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BCD_DEC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Clear wins over a same-cycle increment; the count saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end else if (handoff && err_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_bcd_to_decimal_decoder.sv
// Directed self-checking bench for bcd_to_decimal_decoder (DIGITS=4); covers the error counter when BCD_DEC_ERR_CNT_EN is defined.
module tb_bcd_to_decimal_decoder;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_bcd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_onehot;
    logic        out_err;
    logic [1:0]  out_idx;
    logic        out_last;
`ifdef BCD_DEC_ERR_CNT_EN
    logic        err_clr = 1'b0;
    logic [1:0]  err_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

`ifdef BCD_DEC_ERR_CNT_EN
    bcd_to_decimal_decoder #(.DIGITS(DIGITS), .ERR_CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .err_clr(err_clr), .err_count(err_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .out_err(out_err), .out_idx(out_idx), .out_last(out_last)
    );
`else
    bcd_to_decimal_decoder #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .out_err(out_err), .out_idx(out_idx), .out_last(out_last)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_digit(input string tag, input logic [9:0] oh, input logic err,
                                input logic [1:0] idx);
        #1;
        check({tag, ".valid"},  32'(out_valid),  32'd1);
        check({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
        check({tag, ".err"},    32'(out_err),    32'(err));
        check({tag, ".idx"},    32'(out_idx),    32'(idx));
        check({tag, ".last"},   32'(out_last),   32'(idx == 2'd0));
    endtask

    // oh_flat/errs list the expected digits MSD first: {d3, d2, d1, d0}.
    task automatic send_word(input string tag, input logic [15:0] w,
                             input logic [39:0] oh_flat, input logic [3:0] errs);
        in_bcd    = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) in_valid = 1'b0;
            expect_digit($sformatf("%s.d%0d", tag, 3 - i), oh_flat[(3-i)*10 +: 10], errs[3-i],
                         2'(3 - i));
            check({tag, ".in_ready"}, 32'(in_ready), 32'(i == 3));
        end
        tick();
        check({tag, ".idle"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid"},    32'(out_valid),  32'd0);
        check({tag, ".onehot"},   32'(out_onehot), 32'd0);
        check({tag, ".err"},      32'(out_err),    32'd0);
        check({tag, ".idx"},      32'(out_idx),    32'd0);
        check({tag, ".last"},     32'(out_last),   32'd1);
        check({tag, ".in_ready"}, 32'(in_ready),   32'd1);
`ifdef BCD_DEC_ERR_CNT_EN
        check({tag, ".err_count"}, 32'(err_count), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] b2b_oh [8];
        b2b_oh = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100};

        // Asynchronous reset, observed without any clock edge.
        #1 rst_n = 1'b0;
        #1 check_reset_state("reset");
        tick();
        tick();
        rst_n = 1'b1;

        send_word("w2905", 16'h2905, {10'h004, 10'h200, 10'h001, 10'h020}, 4'b0000);

        // Back-to-back words: the second is accepted in the first word's last cycle.
        in_bcd   = 16'h1234;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) in_bcd = 16'h5678;
            if (i == 4) in_valid = 1'b0;
            expect_digit($sformatf("b2b.%0d", i), b2b_oh[i], 1'b0, 2'(3 - (i % 4)));
            check("b2b.in_ready", 32'(in_ready), 32'((i % 4) == 3));
        end
        tick();
        check("b2b.idle", 32'(out_valid), 32'd0);

        send_word("w9af0", 16'h9AF0, {10'h200, 10'h000, 10'h000, 10'h001}, 4'b0110);
`ifdef BCD_DEC_ERR_CNT_EN
        check("w9af0.err_count", 32'(err_count), 32'd2);
`endif

        // Stall: out_ready 1,0,0,1 with a competing word offered during the stall.
        in_bcd   = 16'h3816;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_digit("stall.d3", 10'h008, 1'b0, 2'd3);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bcd    = 16'h9999;
        expect_digit("stall.s0", 10'h100, 1'b0, 2'd2);
        check("stall.s0.in_ready", 32'(in_ready), 32'd0);
        tick();
        expect_digit("stall.s1", 10'h100, 1'b0, 2'd2);
        check("stall.s1.in_ready", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        expect_digit("stall.d2", 10'h100, 1'b0, 2'd2);
        check("stall.d2.in_ready", 32'(in_ready), 32'd0);
        tick();
        expect_digit("stall.d1", 10'h002, 1'b0, 2'd1);
        tick();
        expect_digit("stall.d0", 10'h040, 1'b0, 2'd0);
        tick();
        check("stall.idle", 32'(out_valid), 32'd0);

        // Reset mid-word at out_idx=1, then a fresh word.
        in_bcd   = 16'h4321;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_digit("rst.d3", 10'h010, 1'b0, 2'd3);
        tick();
        expect_digit("rst.d2", 10'h008, 1'b0, 2'd2);
        tick();
        expect_digit("rst.d1", 10'h004, 1'b0, 2'd1);
        rst_n = 1'b0;
        #1 check_reset_state("midrst");
        tick();
        rst_n = 1'b1;
        send_word("w0007", 16'h0007, {10'h001, 10'h001, 10'h001, 10'h080}, 4'b0000);

`ifdef BCD_DEC_ERR_CNT_EN
        // Six all-error words saturate the 2-bit counter at 3.
        in_bcd    = 16'hFFFF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 23; i++) tick();
        in_valid = 1'b0;
        tick();
        check("sat.idle", 32'(out_valid), 32'd0);
        check("sat.err_count", 32'(err_count), 32'd3);

        // Clear coincides with an errored hand-off and must win.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        err_clr  = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr.err_count", 32'(err_count), 32'd0);
        tick();
        check("clr.inc", 32'(err_count), 32'd1);
        tick();
        tick();
        check("clr.final", 32'(err_count), 32'd3);
        check("clr.idle", 32'(out_valid), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
